// File: rtl/parking_fee_accumulator_if.sv
// Signal bundle between the parking fee engine and its timebase, session
// control and fee consumer. The engine uses the slave view.
interface parking_fee_accumulator_if #(
    parameter int N_SPACES = 4,
    parameter int SEC_W    = 12,
    parameter int COST_W   = 14
);
    localparam int SW = $clog2(N_SPACES);

    logic                tick_1hz;
    logic [4:0]          hour;
    logic                start_valid;
    logic [SW-1:0]       start_space;
    logic                stop_valid;
    logic [SW-1:0]       stop_space;
    logic                stop_ready;
    logic                fee_valid;
    logic                fee_ready;
    logic [SW-1:0]       fee_space;
    logic [COST_W-1:0]   fee_cents;
    logic [SEC_W-1:0]    fee_secs;
    logic [N_SPACES-1:0] active;

    modport slave (
        input  tick_1hz, hour, start_valid, start_space,
        input  stop_valid, stop_space, fee_ready,
        output stop_ready, fee_valid, fee_space, fee_cents, fee_secs, active
    );

    modport master (
        output tick_1hz, hour, start_valid, start_space,
        output stop_valid, stop_space, fee_ready,
        input  stop_ready, fee_valid, fee_space, fee_cents, fee_secs, active
    );
endinterface

// File: rtl/parking_fee_accumulator.sv
// Multi-space time-of-day parking fee engine. Each space runs an IDLE/PARKED
// session with saturating seconds and cost counters; cost is charged per
// billing unit at the rate in force when the unit opens. One fee record is
// emitted per accepted stop through a valid/ready output register.
module parking_fee_accumulator #(
    parameter int N_SPACES    = 4,
    parameter int SEC_W       = 12,
    parameter int COST_W      = 14,
    parameter int BILL_PERIOD = 60,
    parameter int RATE_OFF    = 1,
    parameter int RATE_PEAK   = 2,
    parameter int PEAK_START  = 8,
    parameter int PEAK_END    = 18
) (
    input logic                      clk,
    input logic                      rst,
    parking_fee_accumulator_if.slave bus
);
    localparam int SW   = $clog2(N_SPACES);
    localparam int PH_W = $clog2(BILL_PERIOD);
    localparam logic [SEC_W-1:0]  SEC_MAX  = '1;
    localparam logic [COST_W-1:0] COST_MAX = '1;

    typedef enum logic {IDLE, PARKED} space_state_t;

    space_state_t        state     [N_SPACES];
    space_state_t        state_nxt [N_SPACES];
    logic [SEC_W-1:0]    sec_cnt   [N_SPACES];
    logic [SEC_W-1:0]    sec_nxt   [N_SPACES];
    logic [PH_W-1:0]     phase     [N_SPACES];
    logic [PH_W-1:0]     phase_nxt [N_SPACES];
    logic [COST_W-1:0]   cost      [N_SPACES];
    logic [COST_W-1:0]   cost_nxt  [N_SPACES];

    logic                fee_valid_r, fee_valid_nxt;
    logic [SW-1:0]       fee_space_r, fee_space_nxt;
    logic [COST_W-1:0]   fee_cents_r, fee_cents_nxt;
    logic [SEC_W-1:0]    fee_secs_r,  fee_secs_nxt;

    logic [N_SPACES-1:0] start_hit, stop_hit, active_c;
    logic [COST_W-1:0]   rate_now;
    logic                stop_ready_c;

    // Hours 24..31 are not a valid time of day and bill nothing.
    function automatic logic [COST_W-1:0] rate_of(input logic [4:0] h);
        if (h >= 5'd24)
            return '0;
        else if (h >= 5'(PEAK_START) && h < 5'(PEAK_END))
            return COST_W'(RATE_PEAK);
        else
            return COST_W'(RATE_OFF);
    endfunction

    function automatic logic [COST_W-1:0] sat_add_cost(input logic [COST_W-1:0] a,
                                                       input logic [COST_W-1:0] b);
        logic [COST_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COST_W] ? COST_MAX : s[COST_W-1:0];
    endfunction

    function automatic logic [SEC_W-1:0] sat_inc_sec(input logic [SEC_W-1:0] a);
        return (a == SEC_MAX) ? a : a + 1'b1;
    endfunction

    assign rate_now       = rate_of(bus.hour);
    assign stop_ready_c   = !fee_valid_r || bus.fee_ready;
    assign bus.stop_ready = stop_ready_c;
    assign bus.fee_valid  = fee_valid_r;
    assign bus.fee_space  = fee_space_r;
    assign bus.fee_cents  = fee_cents_r;
    assign bus.fee_secs   = fee_secs_r;
    assign bus.active     = active_c;

    // Next-state for every space and for the fee record register; an accepted
    // stop outranks a start or tick on the same space in the same cycle.
    always_comb begin
        fee_valid_nxt = fee_valid_r;
        fee_space_nxt = fee_space_r;
        fee_cents_nxt = fee_cents_r;
        fee_secs_nxt  = fee_secs_r;
        start_hit     = '0;
        stop_hit      = '0;
        active_c      = '0;
        if (fee_valid_r && bus.fee_ready)
            fee_valid_nxt = 1'b0;
        for (int i = 0; i < N_SPACES; i++) begin
            state_nxt[i] = state[i];
            sec_nxt[i]   = sec_cnt[i];
            phase_nxt[i] = phase[i];
            cost_nxt[i]  = cost[i];
            active_c[i]  = (state[i] == PARKED);
            start_hit[i] = bus.start_valid && (bus.start_space == SW'(i));
            stop_hit[i]  = bus.stop_valid && stop_ready_c &&
                           (bus.stop_space == SW'(i)) && (state[i] == PARKED);
            if (stop_hit[i]) begin
                state_nxt[i]  = IDLE;
                fee_valid_nxt = 1'b1;
                fee_space_nxt = SW'(i);
                fee_cents_nxt = cost[i];
                fee_secs_nxt  = sec_cnt[i];
            end else if (start_hit[i] && state[i] == IDLE) begin
                state_nxt[i] = PARKED;
                sec_nxt[i]   = '0;
                phase_nxt[i] = '0;
                cost_nxt[i]  = '0;
            end else if (state[i] == PARKED && bus.tick_1hz) begin
                if (phase[i] == '0)
                    cost_nxt[i] = sat_add_cost(cost[i], rate_now);
                phase_nxt[i] = (phase[i] == PH_W'(BILL_PERIOD - 1)) ? '0 : phase[i] + 1'b1;
                sec_nxt[i]   = sat_inc_sec(sec_cnt[i]);
            end
        end
    end

    // State and counter registers; reset discards all sessions and any pending record.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SPACES; i++) begin
                state[i]   <= IDLE;
                sec_cnt[i] <= '0;
                phase[i]   <= '0;
                cost[i]    <= '0;
            end
            fee_valid_r <= 1'b0;
            fee_space_r <= '0;
            fee_cents_r <= '0;
            fee_secs_r  <= '0;
        end else begin
            for (int i = 0; i < N_SPACES; i++) begin
                state[i]   <= state_nxt[i];
                sec_cnt[i] <= sec_nxt[i];
                phase[i]   <= phase_nxt[i];
                cost[i]    <= cost_nxt[i];
            end
            fee_valid_r <= fee_valid_nxt;
            fee_space_r <= fee_space_nxt;
            fee_cents_r <= fee_cents_nxt;
            fee_secs_r  <= fee_secs_nxt;
        end
    end
endmodule

// File: tb/tb_parking_fee_accumulator.sv
// Testbench for parking_fee_accumulator: directed scenarios plus randomized
// traffic, with a per-space session model feeding a fee-record scoreboard.
module tb_parking_fee_accumulator;
    localparam int N      = 4;
    localparam int SEC_W  = 8;
    localparam int COST_W = 4;
    localparam int BP     = 60;
    localparam int SECMAX = (1 << SEC_W) - 1;
    localparam int CMAX   = (1 << COST_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parking_fee_accumulator_if #(.N_SPACES(N), .SEC_W(SEC_W), .COST_W(COST_W)) bus();

    parking_fee_accumulator #(
        .N_SPACES(N), .SEC_W(SEC_W), .COST_W(COST_W), .BILL_PERIOD(BP),
        .RATE_OFF(1), .RATE_PEAK(2), .PEAK_START(8), .PEAK_END(18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {int sp; int cents; int secs;} rec_t;
    rec_t sb[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;

    // Reference session state: elapsed ticks kept unclamped, cost clamped.
    bit  m_park  [N];
    int  m_ticks [N];
    int  m_cost  [N];
    bit  m_fv;

    function automatic int m_rate(input int h);
        if (h >= 24) return 0;
        if (h >= 8 && h < 18) return 2;
        return 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model, advanced on each rising edge from the inputs presented.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_park[i] = 0; m_ticks[i] = 0; m_cost[i] = 0;
            end
            m_fv = 0;
            sb.delete();
        end else begin
            bit sr;
            bit stop_ok;
            int ss;
            sr = !m_fv || bus.fee_ready;
            if (m_fv && bus.fee_ready) m_fv = 0;
            ss = int'(bus.stop_space);
            stop_ok = bus.stop_valid && sr && ss < N && m_park[ss];
            for (int i = 0; i < N; i++) begin
                if (stop_ok && ss == i) begin
                    rec_t r;
                    r.sp = i;
                    r.cents = m_cost[i];
                    r.secs = (m_ticks[i] > SECMAX) ? SECMAX : m_ticks[i];
                    sb.push_back(r);
                    m_park[i] = 0;
                    m_fv = 1;
                end else if (bus.start_valid && int'(bus.start_space) == i && !m_park[i]) begin
                    m_park[i] = 1; m_ticks[i] = 0; m_cost[i] = 0;
                end else if (m_park[i] && bus.tick_1hz) begin
                    if (m_ticks[i] % BP == 0) begin
                        m_cost[i] = m_cost[i] + m_rate(int'(bus.hour));
                        if (m_cost[i] > CMAX) m_cost[i] = CMAX;
                    end
                    m_ticks[i]++;
                end
            end
        end
    end

    // Monitor: status outputs against the model, and fee records against the scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] act_exp;
            for (int i = 0; i < N; i++) act_exp[i] = m_park[i];
            check("fee_valid", bus.fee_valid, m_fv);
            check("stop_ready", bus.stop_ready, !m_fv || bus.fee_ready);
            check("active", bus.active, act_exp);
            if (bus.fee_valid === 1'b1 && bus.fee_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_record", bus.fee_space, 64'hFFFF);
                end else begin
                    rec_t r;
                    r = sb.pop_front();
                    check("rec_space", bus.fee_space, r.sp);
                    check("rec_cents", bus.fee_cents, r.cents);
                    check("rec_secs", bus.fee_secs, r.secs);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick(input int n);
        bus.tick_1hz = 1'b1;
        step(n);
        bus.tick_1hz = 1'b0;
    endtask

    task automatic start_sp(input int sp);
        bus.start_valid = 1'b1;
        bus.start_space = 2'(sp);
        step(1);
        bus.start_valid = 1'b0;
    endtask

    task automatic stop_sp(input int sp);
        bus.stop_valid = 1'b1;
        bus.stop_space = 2'(sp);
        step(1);
        bus.stop_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.tick_1hz = 0; bus.hour = 5'd0;
        bus.start_valid = 0; bus.start_space = '0;
        bus.stop_valid = 0; bus.stop_space = '0;
        bus.fee_ready = 1'b1;

        // T1 reset
        step(2);
        check("t1_active", bus.active, 0);
        check("t1_fee_valid", bus.fee_valid, 0);
        check("t1_stop_ready", bus.stop_ready, 1);
        check("t1_fee_cents", bus.fee_cents, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // T2 off-peak ceiling billing
        bus.hour = 5'd3;
        start_sp(0);
        do_tick(61);
        stop_sp(0);
        check("t2_valid", bus.fee_valid, 1);
        check("t2_space", bus.fee_space, 0);
        check("t2_cents", bus.fee_cents, 2);
        check("t2_secs", bus.fee_secs, 61);
        check("t2_active0", bus.active[0], 0);
        step(2);

        // T3 peak then off-peak unit
        bus.hour = 5'd10;
        start_sp(1);
        do_tick(60);
        bus.hour = 5'd20;
        do_tick(1);
        stop_sp(1);
        check("t3_cents", bus.fee_cents, 3);
        check("t3_secs", bus.fee_secs, 61);
        step(2);

        // T4 start+tick and stop+tick collisions
        bus.hour = 5'd3;
        bus.tick_1hz = 1'b1;
        bus.start_valid = 1'b1; bus.start_space = 2'd2;
        step(1);
        bus.start_space = 2'd3;
        bus.stop_valid = 1'b1; bus.stop_space = 2'd2;
        step(1);
        bus.start_valid = 1'b0; bus.stop_valid = 1'b0; bus.tick_1hz = 1'b0;
        check("t4_space", bus.fee_space, 2);
        check("t4_cents", bus.fee_cents, 0);
        check("t4_secs", bus.fee_secs, 0);
        check("t4_active", bus.active, 4'b1000);
        do_tick(5);
        stop_sp(3);
        check("t4_sp3_cents", bus.fee_cents, 1);
        check("t4_sp3_secs", bus.fee_secs, 5);
        step(2);

        // T5 backpressure and back-to-back records
        bus.fee_ready = 1'b0;
        start_sp(0);
        start_sp(1);
        do_tick(2);
        stop_sp(0);
        bus.stop_valid = 1'b1; bus.stop_space = 2'd1;
        step(1);
        check("t5_stop_ready", bus.stop_ready, 0);
        check("t5_held_active1", bus.active[1], 1);
        check("t5_hold_space", bus.fee_space, 0);
        step(2);
        bus.fee_ready = 1'b1;
        step(1);
        bus.stop_valid = 1'b0;
        check("t5_b2b_valid", bus.fee_valid, 1);
        check("t5_b2b_space", bus.fee_space, 1);
        check("t5_b2b_cents", bus.fee_cents, 1);
        check("t5_b2b_secs", bus.fee_secs, 2);
        step(2);

        // T6 cost/seconds saturation and invalid hour
        bus.hour = 5'd10;
        start_sp(0);
        do_tick(9 * BP);
        stop_sp(0);
        check("t6_cents_sat", bus.fee_cents, 15);
        check("t6_secs_sat", bus.fee_secs, SECMAX);
        step(1);
        start_sp(1);
        do_tick(1);
        bus.hour = 5'd25;
        do_tick(60);
        stop_sp(1);
        check("t6_invalid_hour_cents", bus.fee_cents, 2);
        check("t6_invalid_hour_secs", bus.fee_secs, 61);
        step(2);

        // Randomized traffic with a mid-run reset
        for (int k = 0; k < 3000; k++) begin
            bus.tick_1hz    = 1'($urandom_range(0, 1));
            bus.start_valid = ($urandom_range(0, 3) == 0);
            bus.start_space = 2'($urandom_range(0, N - 1));
            bus.stop_valid  = ($urandom_range(0, 9) == 0);
            bus.stop_space  = 2'($urandom_range(0, N - 1));
            bus.fee_ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bus.hour = 5'($urandom_range(0, 31));
            rst = (k == 1500);
            step(1);
        end
        rst = 1'b0;
        bus.tick_1hz = 0; bus.start_valid = 0; bus.stop_valid = 0;
        bus.fee_ready = 1'b1;
        step(5);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
